// File: rtl/chdr_tx_deframer.sv
// chdr_tx_deframer
//   Turns the 64-bit CHDR stream from the crossbar into the 176-bit per-word
//   sample bus used by the TX control stage. Non-data and empty packets are
//   dropped. Packets whose length field disagrees with tlast are trimmed or
//   terminated, so every forwarded packet carries exactly one eop.
//
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     clear           synchronous flush of state/output (counters kept)
//     i_t*            CHDR input stream (AXI-stream style)
//     sample_t*       output beats:
//                       [31:0] sample1, [63:32] sample0, [127:64] send_time,
//                       [159:128] sid, [171:160] seqnum, [172] eop,
//                       [173] eob, [174] send_at, [175] odd
//     drop_count      dropped packets (non-data or empty), saturating
//     len_err_count   packets whose tlast disagreed with length, saturating
module chdr_tx_deframer #(
    parameter int CHECK_LENGTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [63:0]  i_tdata,
    input  logic         i_tlast,
    input  logic         i_tvalid,
    output logic         i_tready,
    output logic [175:0] sample_tdata,
    output logic         sample_tvalid,
    input  logic         sample_tready,
    output logic [15:0]  drop_count,
    output logic [15:0]  len_err_count
);

    typedef enum logic [1:0] {ST_HEADER, ST_TIME, ST_BODY, ST_DRAIN} state_t;

    state_t state, state_nxt;

    // Header field views of the current input word
    logic [1:0]  hdr_type;
    logic        hdr_has_time;
    logic [15:0] hdr_len;
    logic [15:0] hdr_size;
    logic [15:0] payload_bytes;
    logic [15:0] payload_words;
    logic        hdr_reject;

    assign hdr_type      = i_tdata[63:62];
    assign hdr_has_time  = i_tdata[61];
    assign hdr_len       = i_tdata[47:32];
    assign hdr_size      = hdr_has_time ? 16'd16 : 16'd8;
    assign payload_bytes = hdr_len - hdr_size;
    assign payload_words = (payload_bytes + 16'd7) >> 3;
    // Compare before subtracting so a length shorter than the header counts as empty
    assign hdr_reject    = (hdr_type != 2'b00) || (hdr_len <= hdr_size);

    // Latched per-packet context
    logic [11:0] seqnum_r;
    logic        eob_r;
    logic        send_at_r;
    logic [31:0] sid_r;
    logic        odd_r;
    logic [63:0] send_time_r;
    logic [15:0] remaining;

    logic beat;
    logic load;
    logic body_eop;
    logic drop_evt;
    logic len_err_evt;

    assign beat     = i_tvalid & i_tready;
    assign load     = beat & (state == ST_BODY);
    assign body_eop = i_tlast | ((CHECK_LENGTH != 0) && (remaining == 16'd1));

    assign drop_evt = beat & (state == ST_HEADER) & hdr_reject;

    // tlast too early (header/time/body) or length exhausted before tlast
    assign len_err_evt = beat & (
        ((state == ST_HEADER) & ~hdr_reject & i_tlast) |
        ((state == ST_TIME) & i_tlast) |
        ((state == ST_BODY) & ((i_tlast & (remaining > 16'd1)) | (body_eop & ~i_tlast))));

    // State register
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state <= ST_HEADER;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HEADER: begin
                if (beat) begin
                    if (hdr_reject) begin
                        state_nxt = i_tlast ? ST_HEADER : ST_DRAIN;
                    end else if (i_tlast) begin
                        state_nxt = ST_HEADER;
                    end else if (hdr_has_time) begin
                        state_nxt = ST_TIME;
                    end else begin
                        state_nxt = ST_BODY;
                    end
                end
            end
            ST_TIME: begin
                if (beat) begin
                    state_nxt = i_tlast ? ST_HEADER : ST_BODY;
                end
            end
            ST_BODY: begin
                if (beat && body_eop) begin
                    state_nxt = i_tlast ? ST_HEADER : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (beat && i_tlast) begin
                    state_nxt = ST_HEADER;
                end
            end
            default: state_nxt = ST_HEADER;
        endcase
    end

    // Output logic
    always_comb begin
        i_tready = 1'b1;
        if (state == ST_BODY) begin
            i_tready = ~sample_tvalid | sample_tready;
        end
    end

    // Per-packet context capture
    always_ff @(posedge clk) begin
        if (reset) begin
            seqnum_r    <= '0;
            eob_r       <= 1'b0;
            send_at_r   <= 1'b0;
            sid_r       <= '0;
            odd_r       <= 1'b0;
            send_time_r <= '0;
            remaining   <= '0;
        end else if (beat) begin
            case (state)
                ST_HEADER: begin
                    seqnum_r  <= i_tdata[59:48];
                    eob_r     <= i_tdata[60];
                    send_at_r <= hdr_has_time;
                    sid_r     <= i_tdata[31:0];
                    odd_r     <= payload_bytes[2];
                    remaining <= payload_words;
                    if (!hdr_has_time) begin
                        send_time_r <= '0;
                    end
                end
                ST_TIME: send_time_r <= i_tdata;
                ST_BODY: begin
                    if (remaining != 16'd0) begin
                        remaining <= remaining - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register; header context is sampled at load time so context
    // latched for the next packet cannot disturb a held beat
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sample_tvalid <= 1'b0;
            sample_tdata  <= '0;
        end else if (load) begin
            sample_tvalid <= 1'b1;
            sample_tdata  <= {odd_r, send_at_r, eob_r, body_eop, seqnum_r,
                              sid_r, send_time_r, i_tdata};
        end else if (sample_tready) begin
            sample_tvalid <= 1'b0;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count    <= '0;
            len_err_count <= '0;
        end else begin
            if (drop_evt && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
            if (len_err_evt && len_err_count != 16'hFFFF) begin
                len_err_count <= len_err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_chdr_tx_deframer.sv
module tb_chdr_tx_deframer;

    logic         clk = 1'b0;
    logic         reset, clear;
    logic [63:0]  i_tdata;
    logic         i_tlast, i_tvalid, i_tready;
    logic [175:0] sample_tdata;
    logic         sample_tvalid, sample_tready;
    logic [15:0]  drop_count, len_err_count;

    chdr_tx_deframer #(.CHECK_LENGTH(1)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .sample_tdata(sample_tdata), .sample_tvalid(sample_tvalid), .sample_tready(sample_tready),
        .drop_count(drop_count), .len_err_count(len_err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [175:0] exp_q[$];
    logic [63:0]  pkt_q[$];
    int exp_drop = 0;
    int exp_lenerr = 0;
    int emit_first = 0;
    int emit_cnt = 0;
    int rdy_mode = 0;   // 0: ready high, 1: toggle, 2: ready low
    bit chk_en = 1'b0;

    function automatic void check(input string name, input logic [175:0] act, input logic [175:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Packet-level model: computes the beats a whole packet must produce
    task automatic model_pkt();
        logic [63:0] h;
        logic [63:0] t;
        int typ, len, hdrsz, first, n, pb, words, avail, emit;
        logic ht_b, odd_b, eop_b;
        h = pkt_q[0];
        typ = int'(h[63:62]);
        len = int'(h[47:32]);
        ht_b = h[61];
        hdrsz = ht_b ? 16 : 8;
        n = pkt_q.size();
        emit_first = 0;
        emit_cnt = 0;
        if (typ != 0 || len <= hdrsz) begin
            exp_drop++;
            return;
        end
        first = ht_b ? 2 : 1;
        if (n <= first) begin
            exp_lenerr++;
            return;
        end
        pb = len - hdrsz;
        words = (pb + 7) / 8;
        odd_b = ((pb / 4) % 2) == 1;
        t = ht_b ? pkt_q[1] : 64'd0;
        avail = n - first;
        emit = (avail < words) ? avail : words;
        for (int k = 0; k < emit; k++) begin
            eop_b = (k == emit - 1);
            exp_q.push_back({odd_b, ht_b, h[60], eop_b, h[59:48], h[31:0], t, pkt_q[first + k]});
        end
        if (avail != words) exp_lenerr++;
        emit_first = first;
        emit_cnt = emit;
    endtask

    task automatic drive_pkt();
        int n;
        bit acc;
        for (int i = 0; i < pkt_q.size(); i++) begin
            i_tvalid = 1'b1;
            i_tdata  = pkt_q[i];
            i_tlast  = (i == pkt_q.size() - 1);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 200) begin
                @(negedge clk);
                acc = i_tready;
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: word %0d never accepted, required accept within 200 cycles", i);
            end else if (i >= emit_first && i < emit_first + emit_cnt) begin
                check("latency_valid", 176'(sample_tvalid), 176'(1'b1));
                check("latency_data", 176'(sample_tdata[63:0]), 176'(pkt_q[i]));
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        pkt_q.delete();
    endtask

    task automatic send_pkt();
        model_pkt();
        drive_pkt();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || sample_tvalid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending_beats", 176'(exp_q.size()), 176'(0));
    endtask

    task automatic check_counts();
        check("drop_count", 176'(drop_count), 176'(exp_drop));
        check("len_err_count", 176'(len_err_count), 176'(exp_lenerr));
    endtask

    // Downstream ready pattern
    initial begin
        sample_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       sample_tready = 1'b1;
                1:       sample_tready = ~sample_tready;
                default: sample_tready = 1'b0;
            endcase
        end
    end

    // Output compare against the model queue, plus hold-stability under stall
    initial begin
        logic stall_prev;
        logic [175:0] held;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 176'(sample_tvalid), 176'(1'b1));
                    check("hold_data", sample_tdata, held);
                end
                if (sample_tvalid && sample_tready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL extra_beat: got %h expected no beat", sample_tdata);
                    end else begin
                        check("beat", sample_tdata, exp_q.pop_front());
                    end
                end
                stall_prev = sample_tvalid && !sample_tready;
                held = sample_tdata;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        i_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 176'(sample_tvalid), 176'(1'b0));
        check("reset_data", sample_tdata, 176'd0);
        check("reset_drop", 176'(drop_count), 176'(0));
        check("reset_lenerr", 176'(len_err_count), 176'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready", 176'(i_tready), 176'(1'b1));
        chk_en = 1'b1;

        // Plain data packet, two words
        pkt_q = '{64'h0005_0018_0001_0002, 64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444};
        model_pkt();
        check("pin_t1_beat0", exp_q[0], 176'h0005_00010002_0000000000000000_1111111122222222);
        check("pin_t1_beat1", exp_q[1], 176'h1005_00010002_0000000000000000_3333333344444444);
        drive_pkt();
        wait_drain();
        check("t1_drop_literal", 176'(drop_count), 176'(0));

        // Timed packet with a single odd word
        pkt_q = '{64'h2007_0014_0002_0003, 64'h0000_0000_0000_0100, 64'hAAAA_AAAA_BBBB_BBBB};
        model_pkt();
        check("pin_t2_beat0", exp_q[0], 176'hD007_00020003_0000000000000100_AAAAAAAABBBBBBBB);
        drive_pkt();
        wait_drain();
        check_counts();

        // Command packet dropped, following data packet still parsed
        pkt_q = '{64'h8000_0018_0000_0009, 64'h1, 64'h2};
        send_pkt();
        pkt_q = '{64'h0006_0010_0001_0002, 64'h5555_5555_6666_6666};
        send_pkt();
        wait_drain();
        check("t3_drop_literal", 176'(drop_count), 176'(1));
        check_counts();

        // Empty payloads: timed header only (with trailing word), and header-only with tlast
        pkt_q = '{64'h2000_0010_0000_0001, 64'h0};
        send_pkt();
        pkt_q = '{64'h0000_0008_0000_0001};
        send_pkt();
        wait_drain();
        check("empty_drop_literal", 176'(drop_count), 176'(3));

        // Length says one word, three arrive
        pkt_q = '{64'h0008_0010_0000_0004, 64'h7777_7777_8888_8888, 64'h9, 64'hA};
        model_pkt();
        check("pin_t4_beat0", exp_q[0], 176'h1008_00000004_0000000000000000_7777777788888888);
        drive_pkt();
        wait_drain();
        check("t4_lenerr_literal", 176'(len_err_count), 176'(1));

        // Length says three words, tlast on the first
        pkt_q = '{64'h0009_0020_0000_0005, 64'hDEAD_BEEF_0123_4567};
        send_pkt();
        wait_drain();
        check("t5_lenerr_literal", 176'(len_err_count), 176'(2));
        check_counts();

        // Back-to-back four-word packets under toggling ready
        rdy_mode = 1;
        pkt_q = '{64'h000A_0028_0000_0006, 64'hA0, 64'hA1, 64'hA2, 64'hA3};
        send_pkt();
        pkt_q = '{64'h100B_0028_0000_0006, 64'hB0, 64'hB1, 64'hB2, 64'hB3};
        send_pkt();
        rdy_mode = 0;
        wait_drain();
        check_counts();

        // Clear while a beat is held under backpressure
        chk_en = 1'b0;
        rdy_mode = 2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_tvalid = 1'b1;
        i_tlast = 1'b0;
        i_tdata = 64'h0009_0020_0000_0007;
        @(posedge clk);
        #1;
        i_tdata = 64'hCAFE_F00D_0000_0001;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        check("stall_valid", 176'(sample_tvalid), 176'(1'b1));
        check("stall_backpressure", 176'(i_tready), 176'(1'b0));
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_valid", 176'(sample_tvalid), 176'(1'b0));
        check("clear_data", sample_tdata, 176'd0);
        check("clear_ready", 176'(i_tready), 176'(1'b1));
        check_counts();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Stream resumes cleanly after clear
        pkt_q = '{64'h000C_0018_0003_0004, 64'hC0, 64'hC1};
        send_pkt();
        wait_drain();
        check_counts();
        check("final_drop_literal", 176'(drop_count), 176'(3));
        check("final_lenerr_literal", 176'(len_err_count), 176'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
